// File: rtl/tdm_demux.sv
// tdm_demux: recovers two interleaved channels from a 1-bit TDM stream.
// Locks to a frame-sync strobe, steers even slots to channel A and odd
// slots to channel B (both MSB first), and presents both WIDTH-bit words
// together with a one-cycle valid pulse. Framing violations pulse err.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   din    serial multiplexed data, one slot per clock
//   sync   frame-start strobe, high during slot 0
//   ch_a   last complete channel-A word
//   ch_b   last complete channel-B word
//   valid  one-cycle pulse when ch_a/ch_b update
//   sel    slot parity of the bit sampled at the next edge (0 = A, 1 = B)
//   err    one-cycle pulse on a mid-frame sync
module tdm_demux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] ch_a,
  output logic [WIDTH-1:0] ch_b,
  output logic             valid,
  output logic             sel,
  output logic             err
);

  localparam int unsigned SLOTS = 2 * WIDTH;
  localparam int unsigned CW    = $clog2(SLOTS);
  localparam logic [CW-1:0] LAST = CW'(SLOTS - 1);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr_a;
  logic [WIDTH-1:0] sr_b;

  // Counter is held at 0 in HUNT, so its LSB is the slot parity in both states.
  assign sel = cnt[0];

  // Framing state machine, deserializers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      cnt   <= '0;
      sr_a  <= '0;
      sr_b  <= '0;
      ch_a  <= '0;
      ch_b  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        HUNT: begin
          if (sync) begin
            sr_a  <= {sr_a[WIDTH-2:0], din};
            cnt   <= CW'(1);
            state <= RECV;
          end
        end
        RECV: begin
          if (sync) begin
            // Sync always restarts the frame; it is only a violation mid-frame.
            sr_a <= {sr_a[WIDTH-2:0], din};
            cnt  <= CW'(1);
            err  <= (cnt != '0);
          end else if (cnt == '0) begin
            // No sync where the next frame should start: lost lock.
            state <= HUNT;
          end else if (cnt[0]) begin
            sr_b <= {sr_b[WIDTH-2:0], din};
            if (cnt == LAST) begin
              ch_a  <= sr_a;
              ch_b  <= {sr_b[WIDTH-2:0], din};
              valid <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            sr_a <= {sr_a[WIDTH-2:0], din};
            cnt  <= cnt + CW'(1);
          end
        end
        default: begin
          state <= HUNT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
